// File: rtl/regfile_dump_unit.sv
// Debug read-out engine: walks register indices FIRST_REG..LAST_REG over a
// register-file read port and streams each captured value on a valid/ready port.
module regfile_dump_unit #(
  parameter logic [4:0] FIRST_REG = 5'd0,
  parameter logic [4:0] LAST_REG  = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  RdAddr,
  input  logic [31:0] RdData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  ptr;
  logic        hs;

  // Valid/ready: a word transfers on any posedge where out_valid && out_ready;
  // out_data/out_idx/out_last are held stable while out_valid && !out_ready.
  assign hs = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 5'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_idx   <= 5'd0;
      out_last  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start && !abort) ptr <= FIRST_REG;
        end
        READ: begin
          if (!abort) begin
            out_data  <= RdData;
            out_idx   <= ptr;
            out_last  <= (ptr == LAST_REG);
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          // abort wins over a same-cycle handshake; ptr stops at LAST_REG
          if (abort) begin
            out_valid <= 1'b0;
          end else if (hs) begin
            out_valid <= 1'b0;
            if (!out_last) ptr <= ptr + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !abort) state_next = READ;
      READ: state_next = abort ? IDLE : SEND;
      SEND: begin
        if (abort)         state_next = IDLE;
        else if (hs)       state_next = out_last ? DONE : READ;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    RdAddr = 5'd0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      READ: begin
        RdAddr = ptr;
        busy   = 1'b1;
      end
      SEND: busy = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit: a register-file model with write forwarding,
// a full-range instance and a 1..3 instance, each checked by a word scoreboard.
module tb_regfile_dump_unit;

  logic        clk;
  logic        rst;
  logic        start_a, abort_a, ready_a;
  logic [4:0]  rd_addr_a, idx_a;
  logic [31:0] rd_data_a, data_a;
  logic        valid_a, last_a, busy_a, done_a;
  logic        start_b, abort_b, ready_b;
  logic [4:0]  rd_addr_b, idx_b;
  logic [31:0] rd_data_b, data_b;
  logic        valid_b, last_b, busy_b, done_b;

  logic [31:0] regs [32];
  logic        ru_wr;
  logic [4:0]  rd;
  logic [31:0] data_wr;

  logic [37:0] exp_q_a[$];
  logic [37:0] exp_q_b[$];
  int n_checks = 0;
  int n_pass   = 0;

  regfile_dump_unit dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .RdAddr(rd_addr_a), .RdData(rd_data_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
    .out_idx(idx_a), .out_last(last_a), .busy(busy_a), .done(done_a)
  );

  regfile_dump_unit #(.FIRST_REG(5'd1), .LAST_REG(5'd3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .RdAddr(rd_addr_b), .RdData(rd_data_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
    .out_idx(idx_b), .out_last(last_b), .busy(busy_b), .done(done_b)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model: x0 hardwired, write-before-read forwarding
  always @(posedge clk) if (ru_wr && rd != 5'd0) regs[rd] <= data_wr;
  assign rd_data_a = (ru_wr && rd == rd_addr_a && rd != 5'd0) ? data_wr : regs[rd_addr_a];
  assign rd_data_b = (ru_wr && rd == rd_addr_b && rd != 5'd0) ? data_wr : regs[rd_addr_b];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hand-derived register contents: phase 0 = fresh, phase 1 = after x5/x6 writes
  function automatic logic [31:0] exp_val(input int i, input int phase);
    logic [31:0] v;
    v = 32'd0;
    if (i == 2) v = 32'd1024;
    if (phase >= 1 && i == 5) v = 32'hDEADBEEF;
    if (phase >= 1 && i == 6) v = 32'h12345678;
    return v;
  endfunction

  task automatic push_a(input int i, input logic [31:0] d);
    exp_q_a.push_back({(i == 31) ? 1'b1 : 1'b0, 5'(i), d});
  endtask

  task automatic push_b(input int i, input logic [31:0] d);
    exp_q_b.push_back({(i == 3) ? 1'b1 : 1'b0, 5'(i), d});
  endtask

  // monitors: pop one expected word per accepted transfer
  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst && valid_a && ready_a && !abort_a) begin
      if (exp_q_a.size() == 0) begin
        n_checks++;
        $display("FAIL word_a: got unexpected idx %0d data %h, required no word", idx_a, data_a);
      end else begin
        e = exp_q_a.pop_front();
        check("word_a", 64'({last_a, idx_a, data_a}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst && valid_b && ready_b && !abort_b) begin
      if (exp_q_b.size() == 0) begin
        n_checks++;
        $display("FAIL word_b: got unexpected idx %0d data %h, required no word", idx_b, data_b);
      end else begin
        e = exp_q_b.pop_front();
        check("word_b", 64'({last_b, idx_b, data_b}), 64'(e));
      end
    end
  end

  // driver tasks
  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_word_a(input int i);
    int n = 0;
    while (!(valid_a && idx_a == 5'(i)) && n < 200) begin
      tick();
      n++;
    end
    check("wait_word_a", 64'(n < 200), 64'(1));
  endtask

  task automatic wait_rdaddr_a(input int i);
    int n = 0;
    while (!(busy_a && !valid_a && rd_addr_a == 5'(i)) && n < 200) begin
      tick();
      n++;
    end
    check("wait_rdaddr_a", 64'(n < 200), 64'(1));
  endtask

  task automatic wait_done_a();
    int n = 0;
    int pulses = 0;
    while (n < 300) begin
      tick();
      n++;
      if (done_a) pulses++;
      else if (pulses > 0) break;
    end
    check("done_pulse_a", 64'(pulses), 64'(1));
    check("busy_after_a", 64'(busy_a), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(valid_a), 64'(0));
    check({tag, "_busy"},  64'(busy_a),  64'(0));
    check({tag, "_done"},  64'(done_a),  64'(0));
    check({tag, "_rdaddr"}, 64'(rd_addr_a), 64'(0));
    check({tag, "_data"},  64'(data_a),  64'(0));
    check({tag, "_idx"},   64'(idx_a),   64'(0));
    check({tag, "_last"},  64'(last_a),  64'(0));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[2] = 32'd1024;
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
    ru_wr = 1'b0; rd = 5'd0; data_wr = 32'd0;
    tick();
    tick();
    check_reset_outputs("reset");
    check("reset_valid_b", 64'(valid_b), 64'(0));
    rst = 1'b0;
    tick();

    // full dump, consumer always ready
    for (int i = 0; i < 32; i++) push_a(i, exp_val(i, 0));
    pulse_start_a();
    check("t1_busy_read", 64'(busy_a), 64'(1));
    check("t1_rdaddr_first", 64'(rd_addr_a), 64'(0));
    check("t1_valid_read", 64'(valid_a), 64'(0));
    wait_done_a();

    // back-pressure on idx3
    for (int i = 0; i < 32; i++) push_a(i, exp_val(i, 0));
    pulse_start_a();
    wait_word_a(3);
    ready_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_stall_valid", 64'(valid_a), 64'(1));
      check("t2_stall_word", 64'({last_a, idx_a, data_a}), 64'({1'b0, 5'd3, 32'd0}));
    end
    ready_a = 1'b1;
    tick();
    check("t2_after_accept_valid", 64'(valid_a), 64'(0));
    check("t2_after_accept_rdaddr", 64'(rd_addr_a), 64'(4));
    tick();
    check("t2_idx4_valid", 64'(valid_a), 64'(1));
    check("t2_idx4_idx", 64'(idx_a), 64'(4));
    wait_done_a();

    // write forwarding on x5; late write to x6 not reflected
    for (int i = 0; i < 32; i++) push_a(i, (i == 5) ? 32'hDEADBEEF : exp_val(i, 0));
    pulse_start_a();
    wait_rdaddr_a(5);
    ru_wr = 1'b1; rd = 5'd5; data_wr = 32'hDEADBEEF;
    tick();
    ru_wr = 1'b0;
    wait_rdaddr_a(6);
    tick();
    ru_wr = 1'b1; rd = 5'd6; data_wr = 32'h12345678;
    tick();
    ru_wr = 1'b0;
    wait_done_a();

    // abort at idx10 beats a same-cycle handshake, then restart
    for (int i = 0; i < 10; i++) push_a(i, exp_val(i, 1));
    pulse_start_a();
    wait_word_a(10);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("t4_abort_valid", 64'(valid_a), 64'(0));
    check("t4_abort_busy", 64'(busy_a), 64'(0));
    check("t4_abort_done", 64'(done_a), 64'(0));
    tick();
    check("t4_abort_done_later", 64'(done_a), 64'(0));
    for (int i = 0; i < 32; i++) push_a(i, exp_val(i, 1));
    pulse_start_a();
    check("t4_restart_rdaddr", 64'(rd_addr_a), 64'(0));
    wait_done_a();

    // narrow range instance, second start while busy ignored
    for (int i = 1; i <= 3; i++) push_b(i, exp_val(i, 1));
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("t5_rdaddr_first", 64'(rd_addr_b), 64'(1));
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    begin
      int n = 0;
      int pulses = 0;
      while (n < 100) begin
        tick();
        n++;
        if (done_b) pulses++;
        else if (pulses > 0) break;
      end
      check("t5_done_pulse_b", 64'(pulses), 64'(1));
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_idle_busy_b", 64'(busy_b), 64'(0));
    end
    check("t5_queue_b_empty", 64'(exp_q_b.size()), 64'(0));

    // synchronous reset mid-dump at idx7
    for (int i = 0; i < 7; i++) push_a(i, exp_val(i, 1));
    pulse_start_a();
    wait_word_a(7);
    rst = 1'b1;
    tick();
    check_reset_outputs("t6");
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_quiet_valid", 64'(valid_a), 64'(0));
      check("t6_quiet_busy", 64'(busy_a), 64'(0));
    end
    check("queue_a_empty", 64'(exp_q_a.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
